// File: rtl/mips_pkg.sv
// Shared constants for the single-cycle MIPS core: opcodes, R-type function
// codes, the default reset vector and the architecturally named registers.
package mips_pkg;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC00000;

    localparam logic [5:0] OP_SPECIAL = 6'd0;
    localparam logic [5:0] OP_J       = 6'd2;
    localparam logic [5:0] OP_JAL     = 6'd3;
    localparam logic [5:0] OP_BEQ     = 6'd4;
    localparam logic [5:0] OP_BNE     = 6'd5;
    localparam logic [5:0] OP_ADDIU   = 6'd9;
    localparam logic [5:0] OP_SLTI    = 6'd10;
    localparam logic [5:0] OP_SLTIU   = 6'd11;
    localparam logic [5:0] OP_ANDI    = 6'd12;
    localparam logic [5:0] OP_ORI     = 6'd13;
    localparam logic [5:0] OP_XORI    = 6'd14;
    localparam logic [5:0] OP_LUI     = 6'd15;
    localparam logic [5:0] OP_LW      = 6'd35;
    localparam logic [5:0] OP_SW      = 6'd43;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [4:0] REG_V0 = 5'd2;
    localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/mips_regfile.sv
// 32 x 32-bit general purpose register file.
// Ports: clk/rst (async, active-high), two combinational read ports
// (raddr_a/rdata_a, raddr_b/rdata_b), one write port (we/waddr/wdata)
// committed on the rising edge, and v0 which always shows $2.
// $0 reads as zero because writes to it are dropped and reset clears it.
module mips_regfile
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr_a,
    output logic [31:0] rdata_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_b,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    output logic [31:0] v0
);

    logic [31:0] regs_q [32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata_a = regs_q[raddr_a];
    assign rdata_b = regs_q[raddr_b];
    assign v0      = regs_q[REG_V0];

endmodule

// File: rtl/mips_cpu_harvard.sv
// Single-cycle MIPS I subset core with combinational Harvard memory ports.
// Ports: clk, reset (async, active-high), clk_enable (unused), active
// (run/halt), register_v0 ($2), instr_address/instr_readdata (fetch),
// data_address/data_read/data_write/data_writedata/data_readdata (LW/SW).
// The core halts when the PC is updated to zero; only reset restarts it.
module mips_cpu_harvard
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    input  logic        clk_enable,
    output logic [31:0] instr_address,
    input  logic [31:0] instr_readdata,
    output logic [31:0] data_address,
    output logic        data_write,
    output logic        data_read,
    output logic [31:0] data_writedata,
    input  logic [31:0] data_readdata
);

    logic        unused_clk_enable;
    assign unused_clk_enable = clk_enable;

    logic [31:0] pc_q, pc_d;
    logic        active_q, active_d;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] imm_sext, imm_zext, rs_val, rt_val, pc_plus4, mem_addr;
    logic        rf_we, mem_rd, mem_wr;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    assign opcode   = instr_readdata[31:26];
    assign rs       = instr_readdata[25:21];
    assign rt       = instr_readdata[20:16];
    assign rd       = instr_readdata[15:11];
    assign shamt    = instr_readdata[10:6];
    assign funct    = instr_readdata[5:0];
    assign imm_sext = {{16{instr_readdata[15]}}, instr_readdata[15:0]};
    assign imm_zext = {16'h0000, instr_readdata[15:0]};
    assign pc_plus4 = pc_q + 32'd4;
    assign mem_addr = rs_val + imm_sext;

    mips_regfile u_regfile (
        .clk     (clk),
        .rst     (reset),
        .raddr_a (rs),
        .rdata_a (rs_val),
        .raddr_b (rt),
        .rdata_b (rt_val),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .v0      (register_v0)
    );

    always_comb begin
        pc_d     = pc_plus4;
        active_d = active_q;
        rf_we    = 1'b0;
        rf_waddr = rd;
        rf_wdata = '0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        case (opcode)
            OP_SPECIAL: begin
                rf_we = 1'b1;
                case (funct)
                    FN_ADDU: rf_wdata = rs_val + rt_val;
                    FN_SUBU: rf_wdata = rs_val - rt_val;
                    FN_AND:  rf_wdata = rs_val & rt_val;
                    FN_OR:   rf_wdata = rs_val | rt_val;
                    FN_XOR:  rf_wdata = rs_val ^ rt_val;
                    FN_NOR:  rf_wdata = ~(rs_val | rt_val);
                    FN_SLT:  rf_wdata = {31'b0, $signed(rs_val) < $signed(rt_val)};
                    FN_SLTU: rf_wdata = {31'b0, rs_val < rt_val};
                    FN_SLL:  rf_wdata = rt_val << shamt;
                    FN_SRL:  rf_wdata = rt_val >> shamt;
                    FN_SRA:  rf_wdata = $unsigned($signed(rt_val) >>> shamt);
                    FN_SLLV: rf_wdata = rt_val << rs_val[4:0];
                    FN_SRLV: rf_wdata = rt_val >> rs_val[4:0];
                    FN_SRAV: rf_wdata = $unsigned($signed(rt_val) >>> rs_val[4:0]);
                    FN_JR: begin
                        rf_we = 1'b0;
                        pc_d  = rs_val;
                    end
                    FN_JALR: begin
                        rf_wdata = pc_q;
                        pc_d     = rs_val;
                    end
                    default: rf_we = 1'b0;
                endcase
            end
            OP_J:   pc_d = {pc_q[31:28], instr_readdata[25:0], 2'b00};
            OP_JAL: begin
                pc_d     = {pc_q[31:28], instr_readdata[25:0], 2'b00};
                rf_we    = 1'b1;
                rf_waddr = REG_RA;
                rf_wdata = pc_q;
            end
            OP_BEQ: if (rs_val == rt_val) pc_d = pc_plus4 + {imm_sext[29:0], 2'b00};
            OP_BNE: if (rs_val != rt_val) pc_d = pc_plus4 + {imm_sext[29:0], 2'b00};
            OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                rf_we    = 1'b1;
                rf_waddr = rt;
                case (opcode)
                    OP_ADDIU: rf_wdata = rs_val + imm_sext;
                    OP_SLTI:  rf_wdata = {31'b0, $signed(rs_val) < $signed(imm_sext)};
                    OP_SLTIU: rf_wdata = {31'b0, rs_val < imm_sext};
                    OP_ANDI:  rf_wdata = rs_val & imm_zext;
                    OP_ORI:   rf_wdata = rs_val | imm_zext;
                    OP_XORI:  rf_wdata = rs_val ^ imm_zext;
                    default:  rf_wdata = {instr_readdata[15:0], 16'h0000};
                endcase
            end
            OP_LW: begin
                mem_rd   = 1'b1;
                rf_we    = 1'b1;
                rf_waddr = rt;
                rf_wdata = data_readdata;
            end
            OP_SW:   mem_wr = 1'b1;
            default: ;
        endcase

        // Once halted, everything freezes; the halting edge itself still commits.
        if (!active_q) begin
            pc_d   = pc_q;
            rf_we  = 1'b0;
            mem_rd = 1'b0;
            mem_wr = 1'b0;
        end else if (pc_d == 32'h00000000) begin
            active_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= RESET_VECTOR;
            active_q <= 1'b1;
        end else begin
            pc_q     <= pc_d;
            active_q <= active_d;
        end
    end

    assign active         = active_q;
    assign instr_address  = pc_q;
    assign data_read      = mem_rd & ~reset;
    assign data_write     = mem_wr & ~reset;
    assign data_address   = (data_read | data_write) ? mem_addr : 32'h0;
    assign data_writedata = data_write ? rt_val : 32'h0;

endmodule

// File: tb/tb_mips_cpu_harvard.sv
module tb_mips_cpu_harvard;

    logic        clk = 1'b0;
    logic        reset;
    logic        active;
    logic [31:0] register_v0;
    logic        clk_enable;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic [31:0] data_address;
    logic        data_write;
    logic        data_read;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_pc;

    mips_cpu_harvard dut (
        .clk            (clk),
        .reset          (reset),
        .active         (active),
        .register_v0    (register_v0),
        .clk_enable     (clk_enable),
        .instr_address  (instr_address),
        .instr_readdata (instr_readdata),
        .data_address   (data_address),
        .data_write     (data_write),
        .data_read      (data_read),
        .data_writedata (data_writedata),
        .data_readdata  (data_readdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present an instruction mid-cycle, away from the active edge.
    task automatic feed(input logic [31:0] instr, input logic [31:0] rdata);
        @(negedge clk);
        instr_readdata = instr;
        data_readdata  = rdata;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exec(input logic [31:0] instr);
        feed(instr, 32'h0);
        tick();
        exp_pc = exp_pc + 32'd4;
    endtask

    initial begin
        reset          = 1'b1;
        clk_enable     = 1'b1;
        instr_readdata = 32'h0;
        data_readdata  = 32'h0;
        #12;
        check("rst_pc", instr_address, 32'hBFC00000);
        check("rst_active", {31'b0, active}, 32'd1);
        check("rst_v0", register_v0, 32'h0);
        check("rst_strobes", {30'b0, data_read, data_write}, 32'h0);

        @(negedge clk);
        reset = 1'b0;

        feed(32'h08000080, 32'h0);            // J 0x80
        tick();
        check("j_target", instr_address, 32'hB0000200);

        feed(32'h0C000100, 32'h0);            // JAL 0x100
        tick();
        check("jal_target", instr_address, 32'hB0000400);
        exp_pc = 32'hB0000400;

        exec(32'h03E01021);                   // ADDU $2,$31,$0
        check("jal_link", register_v0, 32'hB0000200);

        exec(32'h2402FFFF);                   // ADDIU $2,$0,-1
        check("addiu_neg", register_v0, 32'hFFFFFFFF);
        exec(32'h2C420001);                   // SLTIU $2,$2,1
        check("sltiu", register_v0, 32'h0);
        check("pc_seq", instr_address, exp_pc);

        exec(32'h24020005);                   // ADDIU $2,$0,5
        feed(32'hAC020004, 32'h0);            // SW $2,4($0)
        check("sw_write", {31'b0, data_write}, 32'd1);
        check("sw_read", {31'b0, data_read}, 32'd0);
        check("sw_addr", data_address, 32'h4);
        check("sw_wdata", data_writedata, 32'h5);
        tick();
        exp_pc = exp_pc + 32'd4;
        check("sw_v0_kept", register_v0, 32'h5);

        feed(32'h8C020004, 32'h00001234);     // LW $2,4($0)
        check("lw_read", {31'b0, data_read}, 32'd1);
        check("lw_addr", data_address, 32'h4);
        tick();
        exp_pc = exp_pc + 32'd4;
        check("lw_v0", register_v0, 32'h00001234);

        exec(32'h3C038000);                   // LUI $3,0x8000
        exec(32'h00031103);                   // SRA $2,$3,4
        check("sra", register_v0, 32'hF8000000);
        exec(32'h0060102A);                   // SLT $2,$3,$0
        check("slt", register_v0, 32'h1);
        exec(32'h0060102B);                   // SLTU $2,$3,$0
        check("sltu", register_v0, 32'h0);

        exec(32'h24000007);                   // ADDIU $0,$0,7 (discarded)
        exec(32'h00001021);                   // ADDU $2,$0,$0
        check("r0_zero", register_v0, 32'h0);

        exec(32'h24020009);                   // ADDIU $2,$0,9
        exec(32'hFC000000);                   // unknown opcode
        check("nop_v0", register_v0, 32'h9);
        check("nop_pc", instr_address, exp_pc);

        feed(32'h10000002, 32'h0);            // BEQ $0,$0,+2 (taken)
        tick();
        exp_pc = exp_pc + 32'd12;
        check("beq_taken", instr_address, exp_pc);
        exec(32'h14000005);                   // BNE $0,$0,5 (not taken)
        check("bne_not_taken", instr_address, exp_pc);

        exec(32'h3C040000);                   // LUI $4,0
        exec(32'h34840000);                   // ORI $4,$4,0
        check("pre_halt_active", {31'b0, active}, 32'd1);
        feed(32'h00800008, 32'h0);            // JR $4
        tick();
        check("halt_pc", instr_address, 32'h0);
        check("halt_active", {31'b0, active}, 32'd0);

        feed(32'hAC020004, 32'h0);            // SW while halted
        check("halt_no_write", {31'b0, data_write}, 32'd0);
        tick();
        feed(32'h2402000B, 32'h0);            // ADDIU $2,$0,11 while halted
        check("halt_no_read", {31'b0, data_read}, 32'd0);
        tick();
        check("halt_v0_frozen", register_v0, 32'h9);
        check("halt_pc_frozen", instr_address, 32'h0);

        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rearm_pc", instr_address, 32'hBFC00000);
        check("rearm_active", {31'b0, active}, 32'd1);
        check("rearm_v0", register_v0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
